// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter: arbitrates ALU/load results onto the RF write port and tracks pending writes.
// Optional RF_BYPASS_EN: drops busy during the write cycle and adds rs1_fwd/rs2_fwd.
module rf_writeback_arbiter #(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            wb_en,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            rs1_busy,
    output logic            rs2_busy
`ifdef RF_BYPASS_EN
    ,
    output logic            rs1_fwd,
    output logic            rs2_fwd
`endif
);
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);
    logic [3:0]      starve_q, starve_d;
    logic [31:0]     pend_q, pend_d;
    logic            wb_en_q, wb_en_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [4:0]      sel_rd;
    logic            hit1, hit2;
    // Loads win contention until the ALU has waited STARVE_MAX grants.
    assign alu_ready = rst_n && alu_valid && (!mem_valid || starve_q == SMAX);
    assign mem_ready = rst_n && mem_valid && !alu_ready;
    assign sel_rd    = alu_ready ? alu_rd : mem_rd;
    always_comb begin
        starve_d  = (!alu_valid || alu_ready) ? 4'd0 :
                    (mem_ready && starve_q != 4'hf) ? starve_q + 4'd1 : starve_q;
        wb_en_d   = (alu_ready || mem_ready) && sel_rd != 5'd0;
        wb_rd_d   = wb_en_d ? sel_rd : wb_rd_q;
        wb_data_d = wb_en_d ? (alu_ready ? alu_data : mem_data) : wb_data_q;
        pend_d    = pend_q;
        if (wb_en_q) pend_d[wb_rd_q] = 1'b0;
        if (issue_valid) pend_d[issue_rd] = 1'b1;
        pend_d[0] = 1'b0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q  <= '0;
            pend_q    <= '0;
            wb_en_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else begin
            starve_q  <= starve_d;
            pend_q    <= pend_d;
            wb_en_q   <= wb_en_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
        end
    end
    assign wb_en   = wb_en_q;
    assign wb_rd   = wb_rd_q;
    assign wb_data = wb_data_q;
`ifdef RF_BYPASS_EN
    assign hit1    = wb_en_q && wb_rd_q == rs1;
    assign hit2    = wb_en_q && wb_rd_q == rs2;
    assign rs1_fwd = hit1;
    assign rs2_fwd = hit2;
`else
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
`endif
    assign rs1_busy = rs1 != 5'd0 && pend_q[rs1] && !hit1;
    assign rs2_busy = rs2 != 5'd0 && pend_q[rs2] && !hit2;
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// tb_rf_writeback_arbiter: directed plan cases plus randomized traffic against a behavioural model.
module tb_rf_writeback_arbiter;
    localparam int XLEN = 32;
    localparam int SMAX = 4;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk = 0, rst_n = 0;
    logic issue_valid = 0, alu_valid = 0, mem_valid = 0;
    logic [4:0] issue_rd = 0, alu_rd = 0, mem_rd = 0, rs1 = 0, rs2 = 0;
    logic [XLEN-1:0] alu_data = 0, mem_data = 0;
    logic alu_ready, mem_ready, wb_en, rs1_busy, rs2_busy, rs1_fwd, rs2_fwd;
    logic [4:0] wb_rd;
    logic [XLEN-1:0] wb_data;
    int total = 0, bad = 0;
    bit m_pend [32];
    int m_cnt;
    bit m_en, g_alu, g_mem;
    logic [4:0] m_rd;
    logic [XLEN-1:0] m_data;

    rf_writeback_arbiter #(.XLEN(XLEN), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
`ifdef RF_BYPASS_EN
        , .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd)
`endif
    );
`ifndef RF_BYPASS_EN
    assign rs1_fwd = 1'b0;
    assign rs2_fwd = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 0;
        m_cnt = 0; m_en = 0; m_rd = 0; m_data = 0;
    endtask

    function automatic bit exp_busy(input logic [4:0] rs);
        return rs != 0 && m_pend[rs] && !(BYP && m_en && m_rd == rs);
    endfunction

    // Check all outputs against the model, then advance the model across one clock edge.
    task automatic cyc();
        bit ea, em;
        logic [4:0] rd;
        #1;
        ea = rst_n && alu_valid && (!mem_valid || m_cnt == SMAX);
        em = rst_n && mem_valid && !ea;
        chk("alu_ready", alu_ready, ea);
        chk("mem_ready", mem_ready, em);
        chk("wb_en", wb_en, m_en);
        if (m_en) begin
            chk("wb_rd", wb_rd, m_rd);
            chk("wb_data", wb_data, m_data);
        end
        chk("rs1_busy", rs1_busy, exp_busy(rs1));
        chk("rs2_busy", rs2_busy, exp_busy(rs2));
        chk("rs1_fwd", rs1_fwd, BYP && m_en && m_rd == rs1);
        chk("rs2_fwd", rs2_fwd, BYP && m_en && m_rd == rs2);
        @(posedge clk);
        if (rst_n) begin
            rd = ea ? alu_rd : mem_rd;
            if (m_en) m_pend[m_rd] = 0;
            if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1;
            if (!alu_valid || ea) m_cnt = 0;
            else if (em) m_cnt = m_cnt + 1;
            m_en = (ea || em) && rd != 0;
            if (m_en) begin
                m_rd = rd;
                m_data = ea ? alu_data : mem_data;
            end
            g_alu = ea;
            g_mem = em;
        end
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        cyc(); cyc();
        rst_n = 1;
        // Reset landing in the middle of a load transfer
        issue_valid = 1; issue_rd = 5; cyc();
        issue_valid = 0; mem_valid = 1; mem_rd = 5; mem_data = 32'h55; rs1 = 5; cyc();
        #2 rst_n = 0;
        model_reset();
        #1;
        chk("rst_wb_en", wb_en, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_rs1_busy", rs1_busy, 0);
        chk("rst_mem_ready", mem_ready, 0);
        cyc();
        rst_n = 1; mem_valid = 0; cyc();
        // Single ALU write
        issue_valid = 1; issue_rd = 3; cyc();
        issue_valid = 0; alu_valid = 1; alu_rd = 3; alu_data = 32'hDEADBEEF; rs1 = 3;
        #1 chk("alu_single_ready", alu_ready, 1);
        cyc();
        alu_valid = 0;
        #1;
        chk("alu_single_wb_en", wb_en, 1);
        chk("alu_single_wb_rd", wb_rd, 3);
        chk("alu_single_wb_data", wb_data, 32'hDEADBEEF);
        chk("alu_single_busy_wr", rs1_busy, !BYP);
        cyc();
        #1 chk("alu_single_busy_after", rs1_busy, 0);
        cyc();
        // Contention: loads win STARVE_MAX times, then the ALU is forced through
        alu_valid = 1; alu_rd = 4; alu_data = 32'hA1; mem_valid = 1;
        for (int i = 0; i <= SMAX; i++) begin
            mem_rd = 5'(10 + i); mem_data = 32'(i);
            #1;
            chk("starve_alu", alu_ready, i == SMAX);
            chk("starve_mem", mem_ready, i != SMAX);
            cyc();
        end
        alu_rd = 6; alu_data = 32'hA2; mem_rd = 20;
        #1 chk("starve_cleared", mem_ready, 1);
        cyc();
        alu_valid = 0; mem_valid = 0; cyc(); cyc();
        // Write to x0
        alu_valid = 1; alu_rd = 0; alu_data = 32'h1234; issue_valid = 1; issue_rd = 0; rs1 = 0;
        #1 chk("x0_ready", alu_ready, 1);
        cyc();
        alu_valid = 0; issue_valid = 0;
        #1;
        chk("x0_wb_en", wb_en, 0);
        chk("x0_busy", rs1_busy, 0);
        cyc();
        // Same-cycle clear and set of one register
        issue_valid = 1; issue_rd = 7; cyc();
        issue_valid = 0; alu_valid = 1; alu_rd = 7; alu_data = 32'h77; cyc();
        alu_valid = 0; issue_valid = 1; issue_rd = 7; rs2 = 7;
        #1 chk("setclr_wb_en", wb_en, 1);
        cyc();
        issue_valid = 0;
        #1 chk("setclr_busy", rs2_busy, 1);
        cyc();
        // Randomized traffic with producers holding until accepted
        g_alu = 0; g_mem = 0;
        for (int n = 0; n < 1500; n++) begin
            if (!alu_valid || g_alu) begin
                alu_valid = ($urandom % 3) != 0;
                alu_rd = 5'($urandom_range(0, 7));
                alu_data = $urandom;
            end
            if (!mem_valid || g_mem) begin
                mem_valid = ($urandom % 3) != 0;
                mem_rd = 5'($urandom_range(0, 7));
                mem_data = $urandom;
            end
            issue_valid = 1'($urandom % 2);
            issue_rd = 5'($urandom_range(0, 7));
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            if (n == 700) begin
                #2 rst_n = 0;
                model_reset();
                g_alu = 0; g_mem = 0;
                cyc();
                rst_n = 1;
            end else begin
                cyc();
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
